// File: rtl/imem_loader.sv
// imem_loader -- writes a byte-streamed program image into the instruction
// memory write port and holds the CPU in reset until the image is complete.
//
// Bytes arrive on a valid/ready stream. Each group of four bytes is packed
// little-endian (the first byte is the LSB) into a 32-bit word. Words are
// written at byte addresses 0, 4, 8, ... The last word may be short; its
// missing upper bytes are written as zero and 'partial' is raised.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; begins a load from IDLE or DONE
//   s_valid/s_data/s_last/s_ready   byte stream, s_last marks the final byte
//   mem_we/mem_a/mem_wd             memory write port (mem_a word aligned)
//   busy, done        load in progress / last load finished
//   word_count        words written by the current or last load
//   err_overflow      image was larger than DEPTH_WORDS; the excess is drained
//   partial           final word was zero padded
//   cpu_rst_n         CPU reset, released only in DONE
//
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds csum_exp (sampled on
// start), csum (running sum of written words) and err_csum; a checksum
// mismatch keeps the CPU in reset after the load.
//
// Every output is a register loaded from the next-state decode, so the
// status outputs describe the state being entered at each clock edge.
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic [31:0]       csum_exp,
  output logic [31:0]       csum,
  output logic              err_csum,
`endif
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              busy,
  output logic              done,
  output logic [8:0]        word_count,
  output logic              err_overflow,
  output logic              partial,
  output logic              cpu_rst_n
);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DRAIN, DONE} state_t;

  localparam logic [8:0] DEPTH_WC = 9'(DEPTH_WORDS);

  state_t      state, nxt;
  logic [31:0] wbuf, wbuf_n;       // word under assembly
  logic [1:0]  bidx, bidx_n;       // next byte lane within the word
  logic        last_seen, last_n;  // word in WRITE is the final one
  logic [8:0]  wc_n;
  logic        part_n, ovf_n;
  logic        ld;                 // entering WRITE: capture address/data
  logic        xfer;
  logic        rel_n;              // cpu_rst_n value for the next cycle

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] cexp, cexp_n, csum_n;
  logic        errc_n;
`endif

  // s_ready is registered and is high exactly in COLLECT and DRAIN
  assign xfer = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    wbuf_n = wbuf;
    bidx_n = bidx;
    last_n = last_seen;
    wc_n   = word_count;
    part_n = partial;
    ovf_n  = err_overflow;
    ld     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt    = COLLECT;
          wbuf_n = '0;
          bidx_n = '0;
          last_n = 1'b0;
          wc_n   = '0;
          part_n = 1'b0;
          ovf_n  = 1'b0;
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (word_count == DEPTH_WC) begin
            // memory full: drop the byte and swallow the rest of the image
            ovf_n = 1'b1;
            nxt   = s_last ? DONE : DRAIN;
          end else begin
            wbuf_n[{bidx, 3'b000} +: 8] = s_data;
            if (bidx == 2'd3 || s_last) begin
              nxt    = WRITE;
              ld     = 1'b1;
              last_n = s_last;
              part_n = s_last && (bidx != 2'd3);
              bidx_n = '0;
            end else begin
              bidx_n = bidx + 2'd1;
            end
          end
        end
      end
      WRITE: begin
        wc_n   = word_count + 9'd1;
        wbuf_n = '0;
        nxt    = last_seen ? DONE : COLLECT;
      end
      DRAIN: begin
        if (xfer && s_last) nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_comb begin
    csum_n = csum;
    cexp_n = cexp;
    errc_n = err_csum;
    if ((state == IDLE || state == DONE) && start) begin
      csum_n = '0;
      cexp_n = csum_exp;
      errc_n = 1'b0;
    end
    if (ld) csum_n = csum + wbuf_n;
    // a word is always summed on WRITE entry, so csum is final here
    if (nxt == DONE && state != DONE) errc_n = (csum_n != cexp_n);
    rel_n = (nxt == DONE) && !errc_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum     <= '0;
      cexp     <= '0;
      err_csum <= 1'b0;
    end else begin
      csum     <= csum_n;
      cexp     <= cexp_n;
      err_csum <= errc_n;
    end
  end
`else
  assign rel_n = (nxt == DONE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf         <= '0;
      bidx         <= '0;
      last_seen    <= 1'b0;
      word_count   <= '0;
      partial      <= 1'b0;
      err_overflow <= 1'b0;
      s_ready      <= 1'b0;
      mem_we       <= 1'b0;
      mem_a        <= '0;
      mem_wd       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cpu_rst_n    <= 1'b0;
    end else begin
      wbuf         <= wbuf_n;
      bidx         <= bidx_n;
      last_seen    <= last_n;
      word_count   <= wc_n;
      partial      <= part_n;
      err_overflow <= ovf_n;
      s_ready      <= (nxt == COLLECT) || (nxt == DRAIN);
      mem_we       <= (nxt == WRITE);
      busy         <= (nxt == COLLECT) || (nxt == WRITE) || (nxt == DRAIN);
      done         <= (nxt == DONE);
      cpu_rst_n    <= rel_n;
      if (ld) begin
        mem_a  <= ADDR_W'({word_count, 2'b00});
        mem_wd <= wbuf_n;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk, rst_n, start, s_valid, s_last;
  logic [7:0]  s_data;
  logic        s_ready, mem_we, busy, done, err_overflow, partial, cpu_rst_n;
  logic [9:0]  mem_a;
  logic [31:0] mem_wd;
  logic [8:0]  word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_exp, csum;
  logic        err_csum;
`endif

  imem_loader #(.ADDR_W(10), .DEPTH_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .csum_exp(csum_exp), .csum(csum), .err_csum(err_csum),
`endif
    .s_ready(s_ready), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .busy(busy), .done(done), .word_count(word_count),
    .err_overflow(err_overflow), .partial(partial), .cpu_rst_n(cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  int rdy_viol = 0;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  logic [31:0] img [17] = '{
    32'h010000df, 32'h0800006f, 32'h00e00593, 32'h00500113, 32'h00c00193,
    32'hff718393, 32'h0023e233, 32'h0041f2b3, 32'h004282b3, 32'h02728863,
    32'h0041a233, 32'h00020463, 32'h00000293, 32'h0023a233, 32'h005203b3,
    32'h402383b3, 32'h00008067};

  // write log, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wa.push_back(mem_a);
      wd.push_back(mem_wd);
      if (s_ready) rdy_viol++;
    end
  end

  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeouts++;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_byte(w[8*k +: 8], l && (k == 3));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 10;
    if (s_ready !== 1'b0)      begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
    if (mem_we !== 1'b0)       begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    if (mem_a !== 10'h0)       begin errors++; $display("FAIL rst_mem_a got %h exp 0", mem_a); end
    if (mem_wd !== 32'h0)      begin errors++; $display("FAIL rst_mem_wd got %h exp 0", mem_wd); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    if (word_count !== 9'd0)   begin errors++; $display("FAIL rst_word_count got %0d exp 0", word_count); end
    if (err_overflow !== 1'b0) begin errors++; $display("FAIL rst_err_overflow got %b exp 0", err_overflow); end
    if (partial !== 1'b0)      begin errors++; $display("FAIL rst_partial got %b exp 0", partial); end
    if (cpu_rst_n !== 1'b0)    begin errors++; $display("FAIL rst_cpu_rst_n got %b exp 0", cpu_rst_n); end
    rst_n = 1'b1;
    @(negedge clk);
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'hdf, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    checks += 2;
    if (mem_we !== 1'b1)  begin errors++; $display("FAIL basic_we_after_4th got %b exp 1", mem_we); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_write got %b exp 0", s_ready); end
    send_byte(8'h6f, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h08, 1'b1);
    checks += 2;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL basic_final_we got %b exp 1", mem_we); end
    if (done !== 1'b0)   begin errors++; $display("FAIL basic_done_early got %b exp 0", done); end
    @(negedge clk);
    checks += 4;
    if (done !== 1'b1)      begin errors++; $display("FAIL basic_done got %b exp 1", done); end
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL basic_cpu_rst_n got %b exp 1", cpu_rst_n); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
    if (mem_we !== 1'b0)    begin errors++; $display("FAIL basic_we_done got %b exp 0", mem_we); end
    checks += 4;
    if (wa.size() !== 2)      begin errors++; $display("FAIL basic_nwrites got %0d exp 2", wa.size()); end
    if (word_count !== 9'd2)  begin errors++; $display("FAIL basic_word_count got %0d exp 2", word_count); end
    if (partial !== 1'b0)     begin errors++; $display("FAIL basic_partial got %b exp 0", partial); end
    if (timeouts !== 0)       begin errors++; $display("FAIL basic_timeouts got %0d exp 0", timeouts); end
    if (wa.size() == 2) begin
      checks += 4;
      if (wa[0] !== 10'h000)       begin errors++; $display("FAIL basic_a0 got %h exp 000", wa[0]); end
      if (wd[0] !== 32'h010000df)  begin errors++; $display("FAIL basic_wd0 got %h exp 010000df", wd[0]); end
      if (wa[1] !== 10'h004)       begin errors++; $display("FAIL basic_a1 got %h exp 004", wa[1]); end
      if (wd[1] !== 32'h0800006f)  begin errors++; $display("FAIL basic_wd1 got %h exp 0800006f", wd[1]); end
    end
  endtask

  task automatic test_partial();
    wa.delete(); wd.delete();
    pulse_start();
    checks += 3;
    if (done !== 1'b0)      begin errors++; $display("FAIL part_done_cleared got %b exp 0", done); end
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL part_cpu_rst_n got %b exp 0", cpu_rst_n); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL part_busy got %b exp 1", busy); end
    send_byte(8'h93, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'he0, 1'b1);
    wait_done();
    checks += 5;
    if (done !== 1'b1)       begin errors++; $display("FAIL part_done got %b exp 1", done); end
    if (partial !== 1'b1)    begin errors++; $display("FAIL part_partial got %b exp 1", partial); end
    if (word_count !== 9'd1) begin errors++; $display("FAIL part_word_count got %0d exp 1", word_count); end
    if (wa.size() !== 1)     begin errors++; $display("FAIL part_nwrites got %0d exp 1", wa.size()); end
    if (wd.size() > 0 && (wa[0] !== 10'h000 || wd[0] !== 32'h00e00593)) begin
      errors++; $display("FAIL part_write got %h/%h exp 000/00e00593", wa[0], wd[0]);
    end
  endtask

  task automatic test_back_to_back();
    wa.delete(); wd.delete();
    rdy_viol = 0;
    pulse_start();
    for (int i = 0; i < 17; i++) send_word(img[i], i == 16, 2);
    wait_done();
    checks += 5;
    if (done !== 1'b1)        begin errors++; $display("FAIL b2b_done got %b exp 1", done); end
    if (word_count !== 9'd17) begin errors++; $display("FAIL b2b_word_count got %0d exp 17", word_count); end
    if (wa.size() !== 17)     begin errors++; $display("FAIL b2b_nwrites got %0d exp 17", wa.size()); end
    if (rdy_viol !== 0)       begin errors++; $display("FAIL b2b_ready_in_write got %0d exp 0", rdy_viol); end
    if (partial !== 1'b0)     begin errors++; $display("FAIL b2b_partial got %b exp 0", partial); end
    for (int i = 0; i < 17 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== 10'(i * 4) || wd[i] !== img[i]) begin
        errors++; $display("FAIL b2b_word%0d got %h/%h exp %h/%h", i, wa[i], wd[i], 10'(i * 4), img[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    wa.delete(); wd.delete();
    pulse_start();
    for (int i = 0; i < 257; i++) send_word(32'ha5000000 + 32'(i), i == 256, 0);
    wait_done();
    checks += 5;
    if (done !== 1'b1)         begin errors++; $display("FAIL ovf_done got %b exp 1", done); end
    if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", err_overflow); end
    if (word_count !== 9'd256) begin errors++; $display("FAIL ovf_word_count got %0d exp 256", word_count); end
    if (wa.size() !== 256)     begin errors++; $display("FAIL ovf_nwrites got %0d exp 256", wa.size()); end
    if (cpu_rst_n !== 1'b1)    begin errors++; $display("FAIL ovf_cpu_rst_n got %b exp 1", cpu_rst_n); end
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 10'(i * 4) || wd[i] !== 32'ha5000000 + 32'(i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ovf_data got %0d bad words exp 0", bad); end
    if (wa.size() > 0) begin
      checks++;
      if (wa[$] !== 10'h3fc || wd[$] !== 32'ha50000ff) begin
        errors++; $display("FAIL ovf_last got %h/%h exp 3fc/a50000ff", wa[$], wd[$]);
      end
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_word(img[0], 1'b0, 0);
    send_word(img[1], 1'b0, 0);
    #1 rst_n = 1'b0;
    #1;
    checks += 6;
    if (mem_we !== 1'b0)     begin errors++; $display("FAIL mid_mem_we got %b exp 0", mem_we); end
    if (mem_a !== 10'h0)     begin errors++; $display("FAIL mid_mem_a got %h exp 0", mem_a); end
    if (mem_wd !== 32'h0)    begin errors++; $display("FAIL mid_mem_wd got %h exp 0", mem_wd); end
    if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_busy_ready got %b%b exp 00", busy, s_ready); end
    if (word_count !== 9'd0) begin errors++; $display("FAIL mid_word_count got %0d exp 0", word_count); end
    if (done !== 1'b0 || cpu_rst_n !== 1'b0) begin errors++; $display("FAIL mid_done_cpu got %b%b exp 00", done, cpu_rst_n); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'h12345678, 1'b1, 1);
    wait_done();
    checks += 3;
    if (done !== 1'b1)       begin errors++; $display("FAIL mid_reload_done got %b exp 1", done); end
    if (word_count !== 9'd1) begin errors++; $display("FAIL mid_reload_count got %0d exp 1", word_count); end
    if (wa.size() !== 1 || wa[0] !== 10'h000 || wd[0] !== 32'h12345678) begin
      errors++; $display("FAIL mid_reload_write got n=%0d exp one write 000/12345678", wa.size());
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    csum_exp = 32'h0;
    pulse_start();
    send_word(32'h00000001, 1'b0, 0);
    send_word(32'hffffffff, 1'b1, 0);
    wait_done();
    checks += 3;
    if (done !== 1'b1)      begin errors++; $display("FAIL csum0_done got %b exp 1", done); end
    if (err_csum !== 1'b0)  begin errors++; $display("FAIL csum0_err got %b exp 0", err_csum); end
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL csum0_cpu got %b exp 1", cpu_rst_n); end
    csum_exp = 32'h1;
    pulse_start();
    send_word(32'h00000001, 1'b0, 0);
    send_word(32'hffffffff, 1'b1, 0);
    wait_done();
    checks += 3;
    if (done !== 1'b1)      begin errors++; $display("FAIL csum1_done got %b exp 1", done); end
    if (err_csum !== 1'b1)  begin errors++; $display("FAIL csum1_err got %b exp 1", err_csum); end
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL csum1_cpu got %b exp 0", cpu_rst_n); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_exp = 32'h0;
`endif
    test_reset();
    test_partial();
    test_back_to_back();
    test_overflow();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (timeouts !== 0) begin errors++; $display("FAIL stream_timeouts got %0d exp 0", timeouts); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
